// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one 32-bit load/store as two 16-bit SRAM phases.
// Ports: pipeline side (rd_en, wr_en, address, write_data, read_data, ready),
// SRAM side (sram_addr, sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n).
module mem_access_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic [31:0]   data_q;

  logic          req;
  logic          last;
  logic          next_last;
  logic [31:0]   offset;

  assign req       = rd_en | wr_en;
  assign last      = (cnt == LAST);
  assign next_last = ((cnt + CW'(1)) == LAST);
  assign offset    = address - 32'(ADDR_BASE);

  assign ready = (state == DONE) ||
                 (state == IDLE && !req);

  // Strobes are registered from the next-state view so they line up with
  // the phase/counter they describe; the write strobe lifts one cycle
  // early in each phase to hold address and data stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            cnt         <= '0;
            wr_q        <= wr_en;
            data_q      <= write_data;
            sram_addr   <= {offset[18:2], 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (last) begin
            state        <= HIGH;
            cnt          <= '0;
            sram_addr[0] <= 1'b1;
            sram_dq_out  <= data_q[31:16];
            sram_we_n    <= ~wr_q;
            if (!wr_q)
              read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
            if (next_last)
              sram_we_n <= 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            state      <= DONE;
            cnt        <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!wr_q)
              read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
            if (next_last)
              sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against an
// asynchronous 16-bit SRAM model, default WAIT_CYCLES = 4.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_tests = 0;
  int n_fail  = 0;

  bit [15:0] mem [0:262143];

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dq_out;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns at the same point after DONE.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  bit          mutate,
    output int          frozen,
    output int          we_low,
    output logic [17:0] addr_lo,
    output logic [17:0] addr_hi,
    output logic [31:0] rdata
  );
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    frozen     = 0;
    we_low     = 0;
    addr_lo    = '0;
    addr_hi    = '0;
    rdata      = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (i == 1) addr_lo = sram_addr;
      if (i == 5) addr_hi = sram_addr;
      if (mutate && i == 2) begin
        address    = 32'd2000;
        write_data = 32'h1234_5678;
      end
      if (ready) begin
        rdata = read_data;
        break;
      end
      frozen++;
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  int          fz;
  int          wl;
  logic [17:0] alo;
  logic [17:0] ahi;
  logic [31:0] rd;

  initial begin
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    write_data = '0;

    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF,
               1'b0, fz, wl, alo, ahi, rd);
    chk("st_frozen", fz, 9);
    chk("st_we_low", wl, 6);
    chk("st_mem0", {16'd0, mem[0]}, 32'h0000_BEEF);
    chk("st_mem1", {16'd0, mem[1]}, 32'h0000_DEAD);

    mem[2] = 16'h5678;
    mem[3] = 16'h1234;
    run_access(1'b1, 1'b0, 32'd1028, 32'd0,
               1'b0, fz, wl, alo, ahi, rd);
    chk("ld_frozen", fz, 9);
    chk("ld_we_low", wl, 0);
    chk("ld_addr_lo", {14'd0, alo}, 32'd2);
    chk("ld_addr_hi", {14'd0, ahi}, 32'd3);
    chk("ld_rdata", rd, 32'h1234_5678);
    @(negedge clk);
    chk("ld_hold", read_data, 32'h1234_5678);
    @(posedge clk);
    #1;

    run_access(1'b0, 1'b1, 32'd1032, 32'hA5A5_0001,
               1'b0, fz, wl, alo, ahi, rd);
    chk("b2b_st_frozen", fz, 9);
    run_access(1'b1, 1'b0, 32'd1032, 32'd0,
               1'b0, fz, wl, alo, ahi, rd);
    chk("b2b_ld_frozen", fz, 9);
    chk("b2b_rdata", rd, 32'hA5A5_0001);

    run_access(1'b1, 1'b1, 32'd1024, 32'h0000_FFFF,
               1'b1, fz, wl, alo, ahi, rd);
    chk("sim_frozen", fz, 9);
    chk("sim_mem0", {16'd0, mem[0]}, 32'h0000_FFFF);
    chk("sim_mem1", {16'd0, mem[1]}, 32'h0000_0000);
    chk("sim_mem488", {16'd0, mem[488]}, 32'd0);
    chk("sim_rdata_kept", read_data, 32'hA5A5_0001);

    mem[18'h3FFFE] = 16'h0BAD;
    mem[18'h3FFFF] = 16'hF00D;
    run_access(1'b1, 1'b0, 32'd1020, 32'd0,
               1'b0, fz, wl, alo, ahi, rd);
    chk("wrap_addr_lo", {14'd0, alo}, 32'h3FFFE);
    chk("wrap_addr_hi", {14'd0, ahi}, 32'h3FFFF);
    chk("wrap_rdata", rd, 32'hF00D_0BAD);

    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rw_we_before", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rw_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rw_rdata", read_data, 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk("rw_ready2", {31'd0, ready}, 32'd1);
    chk("rw_we_n2", {31'd0, sram_we_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory controller between the MEM stage and an external 16-bit asynchronous SRAM. It turns a single-cycle 32-bit load or store request into two sequenced half-word SRAM accesses. While the access is in progress it drives `ready` low; the pipeline uses `~ready` as the `freeze` input of every stage register, including the MEM-stage register. It returns the assembled 32-bit load value with `ready` high in the final cycle, so the MEM-stage register captures it on that edge.

## Interface
Parameters:
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, default 4: cycles held per half-word phase. Legal range is ≥2.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `rd_en`, in, 1: load request (the MEM_R_en of the instruction in MEM).
- `wr_en`, in, 1: store request.
- `address`, in, 32: byte address (ALU result).
- `write_data`, in, 32: store data.
- `read_data`, out, 32: assembled load value.
- `ready`, out, 1: 1 = no access pending or access completing this cycle.
- `sram_addr`, out, 18: SRAM half-word address.
- `sram_dq_out`, out, 16: write data to SRAM.
- `sram_dq_in`, in, 16: read data from SRAM.
- `sram_dq_oe`, out, 1: 1 = controller drives the DQ bus.
- `sram_we_n`, out, 1: SRAM write strobe, active-low.

## Operation
- Address arithmetic:
  - `word = (address - ADDR_BASE) >> 2`, keeping bits [16:0] (modulo 2^17; no range error).
  - `sram_addr = {word, phase}`, where the LOW phase uses 0 and the HIGH phase uses 1.
- Request capture:
  - The request kind, `address` and `write_data` are sampled into internal registers on the IDLE→LOW edge.
  - Later changes to the inputs do not affect an access already in progress.
- Request priority: `rd_en && wr_en` is treated as a write.
- States:
  - IDLE:
    - Any request goes to LOW, counter = 0.
    - With no request, stays in IDLE.
  - LOW: half-word 0 (bits [15:0]).
    - Counter increments each cycle.
    - When counter = WAIT_CYCLES-1, goes to HIGH and clears the counter.
  - HIGH: half-word 1 (bits [31:16]); same counting as LOW; goes to DONE.
  - DONE: one cycle, then IDLE.
- Writes:
  - `sram_dq_oe` = 1 throughout LOW and HIGH.
  - `sram_dq_out` = captured data [15:0] in LOW and [31:16] in HIGH.
  - `sram_we_n` = 0 for counter < WAIT_CYCLES-1 and 1 on the last cycle of each phase (address/data hold).
- Reads:
  - `sram_we_n` = 1 and `sram_dq_oe` = 0.
  - `sram_dq_in` is sampled on the last cycle of LOW into `read_data[15:0]`, and on the last cycle of HIGH into `read_data[31:16]`.
  - `read_data` holds its value until the next read completes; writes never modify it.
- `ready` (combinational) = `(state == DONE) || (state == IDLE && !rd_en && !wr_en)`.
- Aborts:
  - Dropping the request mid-access does not abort the access; it runs to DONE.
  - A request present in IDLE on the cycle after DONE starts a new access; back-to-back accesses are legal.
- Outside LOW and HIGH:
  - `sram_we_n` = 1 and `sram_dq_oe` = 0.
  - `sram_addr` and `sram_dq_out` hold their last value and have no meaning.

## Timing
- Reset values (`rst` = 0, immediate, asynchronous):
  - State IDLE, counter 0, `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `sram_dq_oe` = 0 and `sram_we_n` = 1.
  - `ready` = 1 while no request is present.
- Reset mid-access: the SRAM write in progress is abandoned (partial half-word possible) and the state returns to IDLE. Strobes must deassert in the same cycle that `rst` falls.
- Latency:
  - A request first seen in IDLE at cycle 0 has `ready` = 0 in cycles 0 through 2·WAIT_CYCLES.
  - `ready` = 1 in cycle 2·WAIT_CYCLES+1 (DONE), with `read_data` valid in that cycle.
  - Total is 2·WAIT_CYCLES+2 cycles per access. With the default this is 10 cycles, 9 of them frozen.
- No-request cycles: `ready` stays 1 with zero latency.

## Test plan
- **Store:** WAIT_CYCLES=4, store 0xDEADBEEF to 1024.
  - SRAM model gets [0]=0xBEEF, [1]=0xDEAD.
  - `sram_we_n` is low for 3 cycles per phase.
  - `ready` is low for exactly 9 cycles, then high for 1.
- **Load:** preload SRAM [2]=0x5678, [3]=0x1234, then load from 1028.
  - `sram_addr` sequence is 2 then 3.
  - `read_data` = 0x12345678 in the DONE cycle and holds it after.
- **Back-to-back:** store 0xA5A5_0001 to 1032, then a load from 1032 in the next IDLE cycle.
  - The second access starts with no gap.
  - `read_data` = 0xA5A50001.
- **Reset mid-write:** assert `rst` = 0 on LOW counter = 1 of a store.
  - `sram_we_n` = 1, `sram_dq_oe` = 0 and `read_data` = 0 immediately.
  - After release, state is IDLE and `ready` = 1.
- **Simultaneous and changing inputs:** assert `rd_en` = `wr_en` = 1 with data 0x0000FFFF at 1024.
  - It performs a write: SRAM [0]=0xFFFF, [1]=0x0000.
  - Changing `address` and `write_data` during the access has no effect.
- **Wrap-around:** load at `address` = 1020.
  - `word` wraps to 0x1FFFF, so `sram_addr` = 0x3FFFE, then 0x3FFFF.
